// File: rtl/csr_trap_sequencer.sv
// Hardware CSR writer for machine-mode trap entry and mret return, with PC redirect.
// Optional mtval write is enabled by defining CSR_TRAP_MTVAL_EN.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module csr_trap_sequencer #(
  parameter int                             XLEN          = `XLEN_64b,
  parameter logic [(1<<(XLEN+4))-1:0]       TRAP_PC_RESET = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_trap_req,
  input  logic [(1<<(XLEN+4))-1:0]   i_trap_cause,
  input  logic [(1<<(XLEN+4))-1:0]   i_trap_pc,
  input  logic [(1<<(XLEN+4))-1:0]   i_trap_tval,
  input  logic                       i_mret_req,
  input  logic [(1<<(XLEN+4))-1:0]   i_mstatus,
  input  logic [(1<<(XLEN+4))-1:0]   i_mtvec,
  input  logic [(1<<(XLEN+4))-1:0]   i_mepc,
  output logic                       o_csr_we,
  output logic [11:0]                o_csr_addr,
  output logic [(1<<(XLEN+4))-1:0]   o_csr_wdata,
  output logic                       o_busy,
  output logic                       o_flush,
  output logic                       o_redirect_valid,
  output logic [(1<<(XLEN+4))-1:0]   o_redirect_pc
);
  localparam int W = 1 << (XLEN + 4);
  localparam logic [W-1:0] ALIGN_MASK   = {{(W-2){1'b1}}, 2'b00};
  localparam logic [11:0]  CSR_MSTATUS  = 12'h300;
  localparam logic [11:0]  CSR_MEPC     = 12'h341;
  localparam logic [11:0]  CSR_MCAUSE   = 12'h342;
  localparam logic [11:0]  CSR_MTVAL    = 12'h343;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, W_MSTATUS_RET, REDIRECT
  } state_e;

  // Requests are single-cycle samples taken only in IDLE (o_busy low); while
  // o_busy is high the pipeline must hold its request, it is not queued here.
  state_e         state_q, state_d;
  logic [W-1:0]   cause_q, cause_d;
  logic [W-1:0]   tval_q, tval_d;
  logic           we_q, we_d;
  logic [11:0]    addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic           busy_q, busy_d;
  logic           flush_q, flush_d;
  logic           rvalid_q, rvalid_d;
  logic [W-1:0]   rpc_q, rpc_d;
  logic [W-1:0]   mtvec_base;
  logic [W-1:0]   trap_target;

  function automatic logic [W-1:0] mstatus_on_trap(input logic [W-1:0] m);
    logic [W-1:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [W-1:0] mstatus_on_mret(input logic [W-1:0] m);
    logic [W-1:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Vectored mode applies to interrupts only; offset is cause*4, wrapping mod 2^W.
  assign mtvec_base  = i_mtvec & ALIGN_MASK;
  assign trap_target = (i_mtvec[1:0] == 2'b01 && cause_q[W-1])
                       ? mtvec_base + {cause_q[W-3:0], 2'b00}
                       : mtvec_base;

`ifdef CSR_TRAP_MTVAL_EN
  always_comb tval_d = (state_q == IDLE && i_trap_req) ? i_trap_tval : tval_q;
`else
  logic unused_tval;
  assign unused_tval = ^{i_trap_tval, tval_q};
  always_comb tval_d = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    we_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    busy_d   = 1'b1;
    flush_d  = 1'b1;
    rvalid_d = 1'b0;
    rpc_d    = rpc_q;
    case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        flush_d = 1'b0;
        if (i_trap_req) begin
          state_d = W_MEPC;
          cause_d = i_trap_cause;
          busy_d  = 1'b1;
          flush_d = 1'b1;
          we_d    = 1'b1;
          addr_d  = CSR_MEPC;
          wdata_d = i_trap_pc & ALIGN_MASK;
        end else if (i_mret_req) begin
          state_d = W_MSTATUS_RET;
          busy_d  = 1'b1;
          flush_d = 1'b1;
          we_d    = 1'b1;
          addr_d  = CSR_MSTATUS;
          wdata_d = mstatus_on_mret(i_mstatus);
        end
      end
      W_MEPC: begin
        state_d = W_MCAUSE;
        we_d    = 1'b1;
        addr_d  = CSR_MCAUSE;
        wdata_d = cause_q;
      end
`ifdef CSR_TRAP_MTVAL_EN
      W_MCAUSE: begin
        state_d = W_MTVAL;
        we_d    = 1'b1;
        addr_d  = CSR_MTVAL;
        wdata_d = tval_q;
      end
      W_MTVAL: begin
        state_d = W_MSTATUS;
        we_d    = 1'b1;
        addr_d  = CSR_MSTATUS;
        wdata_d = mstatus_on_trap(i_mstatus);
      end
`else
      W_MCAUSE: begin
        state_d = W_MSTATUS;
        we_d    = 1'b1;
        addr_d  = CSR_MSTATUS;
        wdata_d = mstatus_on_trap(i_mstatus);
      end
`endif
      W_MSTATUS: begin
        state_d  = REDIRECT;
        rvalid_d = 1'b1;
        rpc_d    = trap_target;
      end
      W_MSTATUS_RET: begin
        state_d  = REDIRECT;
        rvalid_d = 1'b1;
        rpc_d    = i_mepc & ALIGN_MASK;
      end
      REDIRECT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        flush_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      tval_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      flush_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rpc_q    <= TRAP_PC_RESET;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      flush_q  <= flush_d;
      rvalid_q <= rvalid_d;
      rpc_q    <= rpc_d;
    end
  end

  assign o_csr_we         = we_q;
  assign o_csr_addr       = addr_q;
  assign o_csr_wdata      = wdata_q;
  assign o_busy           = busy_q;
  assign o_flush          = flush_q;
  assign o_redirect_valid = rvalid_q;
  assign o_redirect_pc    = rpc_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Self-checking bench for csr_trap_sequencer: vector table of trap/mret
// transactions plus hand sequences for busy-ignore and mid-sequence reset.
module tb_csr_trap_sequencer;
  localparam int W = 64;
  localparam logic [W-1:0] RST_PC = 64'hABCD_0000_0000_1230;
`ifdef CSR_TRAP_MTVAL_EN
  localparam int NW_TRAP = 4;
`else
  localparam int NW_TRAP = 3;
`endif

  logic          clk;
  logic          rst;
  logic          trap_req;
  logic [W-1:0]  trap_cause;
  logic [W-1:0]  trap_pc;
  logic [W-1:0]  trap_tval;
  logic          mret_req;
  logic [W-1:0]  mstatus;
  logic [W-1:0]  mtvec;
  logic [W-1:0]  mepc;
  logic          csr_we;
  logic [11:0]   csr_addr;
  logic [W-1:0]  csr_wdata;
  logic          busy;
  logic          flush;
  logic          rvalid;
  logic [W-1:0]  rpc;

  csr_trap_sequencer #(.TRAP_PC_RESET(RST_PC)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_trap_req       (trap_req),
    .i_trap_cause     (trap_cause),
    .i_trap_pc        (trap_pc),
    .i_trap_tval      (trap_tval),
    .i_mret_req       (mret_req),
    .i_mstatus        (mstatus),
    .i_mtvec          (mtvec),
    .i_mepc           (mepc),
    .o_csr_we         (csr_we),
    .o_csr_addr       (csr_addr),
    .o_csr_wdata      (csr_wdata),
    .o_busy           (busy),
    .o_flush          (flush),
    .o_redirect_valid (rvalid),
    .o_redirect_pc    (rpc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         trap;
    logic         mret;
    logic [W-1:0] cause;
    logic [W-1:0] pc;
    logic [W-1:0] tval;
    logic [W-1:0] mtvec;
    logic [W-1:0] mstatus;
    logic [W-1:0] mepc;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_mstat;
  } vec_t;

  vec_t               vecs[8];
  logic [12+W-1:0]    exp_q[$];
  int                 checks;
  int                 failures;
  string              tag;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s act=%h exp=%h", tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap_req = 1'b0;
    mret_req = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_we", W'(csr_we), '0);
    chk("rst_addr", W'(csr_addr), '0);
    chk("rst_wdata", csr_wdata, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_flush", W'(flush), '0);
    chk("rst_rvalid", W'(rvalid), '0);
    chk("rst_rpc", rpc, RST_PC);
  endtask

  task automatic drive_vec(input vec_t v);
    trap_req   = v.trap;
    mret_req   = v.mret;
    trap_cause = v.cause;
    trap_pc    = v.pc;
    trap_tval  = v.tval;
    mtvec      = v.mtvec;
    mstatus    = v.mstatus;
    mepc       = v.mepc;
  endtask

  // Driver + scoreboard for one table entry
  task automatic run_vec(input int idx);
    vec_t            v;
    int              nw;
    logic [12+W-1:0] e;
    v   = vecs[idx];
    tag = $sformatf("v%0d", idx);
    exp_q.delete();
    if (v.trap) begin
      nw = NW_TRAP;
      exp_q.push_back({12'h341, v.pc & ~64'h3});
      exp_q.push_back({12'h342, v.cause});
`ifdef CSR_TRAP_MTVAL_EN
      exp_q.push_back({12'h343, v.tval});
`endif
      exp_q.push_back({12'h300, v.exp_mstat});
    end else begin
      nw = 1;
      exp_q.push_back({12'h300, v.exp_mstat});
    end
    drive_vec(v);
    step();
    idle_inputs();
    for (int k = 1; k <= nw + 2; k++) begin
      chk($sformatf("we_c%0d", k), W'(csr_we), W'(k <= nw));
      if (csr_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s extra_write_c%0d act=%h exp=none", tag, k, csr_addr);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("addr_c%0d", k), W'(csr_addr), W'(e[W+11:W]));
          chk($sformatf("wdata_c%0d", k), csr_wdata, e[W-1:0]);
        end
      end
      chk($sformatf("busy_c%0d", k), W'(busy), W'(k <= nw + 1));
      chk($sformatf("flush_c%0d", k), W'(flush), W'(k <= nw + 1));
      chk($sformatf("rvalid_c%0d", k), W'(rvalid), W'(k == nw + 1));
      if (k >= nw + 1) chk($sformatf("rpc_c%0d", k), rpc, v.exp_pc);
      step();
    end
    chk("q_empty", W'(exp_q.size()), '0);
  endtask

  initial begin
    int wr_cnt;
    int rv_cnt;
    checks   = 0;
    failures = 0;
    tag      = "init";

    //                 trap  mret  cause                    pc                tval     mtvec                    mstatus                  mepc                     exp_pc                   exp_mstat
    vecs[0] = '{1'b1, 1'b0, 64'd2,                   64'h8000_0102,    64'hDEAD, 64'h8000_1001,           64'h8,                   64'h0,                   64'h8000_1000,           64'h1880};
    vecs[1] = '{1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h200,          64'h0,    64'h1001,                64'h1888,                64'h0,                   64'h101C,                64'h1880};
    vecs[2] = '{1'b1, 1'b0, 64'd7,                   64'h204,          64'h11,   64'h1001,                64'h0,                   64'h0,                   64'h1000,                64'h1800};
    vecs[3] = '{1'b0, 1'b1, 64'h0,                   64'h0,            64'h0,    64'h0,                   64'h1880,                64'h4002,                64'h4000,                64'h1888};
    vecs[4] = '{1'b0, 1'b1, 64'h0,                   64'h0,            64'h0,    64'h0,                   64'h8,                   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1880};
    vecs[5] = '{1'b1, 1'b1, 64'd3,                   64'h1237,         64'h55,   64'h2000,                64'h0,                   64'h9999,                64'h2000,                64'h1800};
    vecs[6] = '{1'b1, 1'b0, 64'h8000_0000_0000_0040, 64'h0,            64'h77,   64'hFFFF_FFFF_FFFF_FF01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   64'h0,                   64'hFFFF_FFFF_FFFF_FFF7};
    vecs[7] = '{1'b1, 1'b0, 64'h8000_0000_0000_0003, 64'h300,          64'h0,    64'h3003,                64'h80,                  64'h0,                   64'h3000,                64'h1800};

    rst = 1'b1;
    idle_inputs();
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mstatus = '0; mtvec = '0; mepc = '0;
    step(); step(); step();
    tag = "reset";
    chk_reset_outputs();
    rst = 1'b0;
    step();
    chk_reset_outputs();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Requests pulsed while busy must be ignored
    tag = "busy_ign";
    wr_cnt = 0;
    rv_cnt = 0;
    drive_vec(vecs[0]);
    step();
    idle_inputs();
    for (int k = 1; k <= 12; k++) begin
      if (csr_we) wr_cnt++;
      if (rvalid) rv_cnt++;
      if (csr_we && csr_addr == 12'h342) chk("mcause_kept", csr_wdata, 64'd2);
      trap_req   = (k == 2);
      trap_cause = (k == 2) ? 64'd9 : 64'd2;
      mret_req   = (k == NW_TRAP + 1);
      step();
    end
    idle_inputs();
    chk("writes", W'(wr_cnt), W'(NW_TRAP));
    chk("redirects", W'(rv_cnt), 64'd1);
    chk("busy_end", W'(busy), '0);

    // Reset while the mcause write is on the port
    tag = "mid_reset";
    drive_vec(vecs[1]);
    step();
    idle_inputs();
    step();
    chk("in_mcause", W'(csr_addr), 64'h342);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs();
    wr_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (csr_we) wr_cnt++;
      chk($sformatf("busy_after_c%0d", k), W'(busy), '0);
      step();
    end
    chk("no_writes", W'(wr_cnt), '0);

    // Sequencer must be usable again after the abort
    run_vec(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
